// File: rtl/mt_regfile.sv
// mt_regfile: one shared register bank for every hardware thread of the
// barrel-threaded core.
// - Two registered read ports; both read the same thread in a given cycle.
// - One writeback write port.
// - A multi-cycle init walker rebuilds one thread's context while the other
//   threads keep writing.
// - r0 and r1 are not stored. r0 reads as 0 and r1 reads as the thread ID.
module mt_regfile #(
  parameter int unsigned       NUM_TRD      = 8,
  parameter int unsigned       NUM_REG      = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] STACK_TOP    = DATA_W'(32'h0000_FFFC),
  parameter logic [DATA_W-1:0] STACK_STRIDE = DATA_W'(32'h0000_1000),
  localparam int unsigned      TRD_W        = $clog2(NUM_TRD),
  localparam int unsigned      REG_W        = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode-side read request
  input  logic [TRD_W-1:0]  rd_trd,
  input  logic [REG_W-1:0]  rd_reg_a,
  input  logic [REG_W-1:0]  rd_reg_b,
  // writeback port
  input  logic              wr_en,
  input  logic [TRD_W-1:0]  wr_trd,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  // context init request
  input  logic              init_req,
  input  logic [TRD_W-1:0]  init_trd,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_ready,
  output logic              init_done,
  // registered read data
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  // ---------------------------------------------------------------------
  // Init walker state
  // ---------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } walk_state_e;

  walk_state_e       state_q;
  logic [TRD_W-1:0]  wtrd_q;        // thread whose context is being rebuilt
  logic [DATA_W-1:0] warg_q;        // argument value destined for r4
  logic [REG_W-1:0]  widx_q;        // register written by the walker this cycle
  logic              init_ready_q;
  logic              init_done_q;

  logic              accept;
  logic              walk_we;
  logic [DATA_W-1:0] esp;
  logic [DATA_W-1:0] walk_data;

  // Writeback qualification
  logic              wr_drop;
  logic              wr_fire;

  // Read path
  logic [REG_W-1:0]  port_reg [2];
  logic [DATA_W-1:0] port_val [2];
  logic [DATA_W-1:0] bank_rd  [2][NUM_TRD];
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;

  assign accept  = init_req && init_ready_q;
  assign walk_we = (state_q == S_WALK);

  // Stack pointer of the walked thread. The product wraps at DATA_W bits.
  assign esp = STACK_TOP - (DATA_W'(wtrd_q) * STACK_STRIDE);

  // Value the walker stores this cycle.
  // - r2 and r3 receive the stack pointer.
  // - r4 receives the argument.
  // - All other registers are cleared.
  always_comb begin
    walk_data = '0;
    if ((widx_q == REG_W'(2)) || (widx_q == REG_W'(3))) begin
      walk_data = esp;
    end else if (widx_q == REG_W'(4)) begin
      walk_data = warg_q;
    end
  end

  // Writeback to the thread being initialised is discarded for the whole
  // walk, including the accept cycle. The walker and the writeback port
  // therefore never target the same thread in the same cycle.
  assign wr_drop = (walk_we && (wr_trd == wtrd_q)) ||
                   (accept  && (wr_trd == init_trd));
  assign wr_fire = wr_en && (wr_reg >= REG_W'(2)) && !wr_drop;

  // Walker FSM. Accept a request, step through r2..r(NUM_REG-1), then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wtrd_q       <= '0;
      warg_q       <= '0;
      widx_q       <= '0;
      init_ready_q <= 1'b1;
      init_done_q  <= 1'b0;
    end else begin
      init_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_req) begin
            state_q      <= S_WALK;
            wtrd_q       <= init_trd;
            warg_q       <= init_data;
            widx_q       <= REG_W'(2);
            init_ready_q <= 1'b0;
          end
        end
        S_WALK: begin
          widx_q <= widx_q + REG_W'(1);
          if (widx_q == REG_W'(NUM_REG - 1)) begin
            state_q      <= S_IDLE;
            init_ready_q <= 1'b1;
            init_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          init_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_ready = init_ready_q;
  assign init_done  = init_done_q;

  // ---------------------------------------------------------------------
  // Register bank: one slice per thread
  // ---------------------------------------------------------------------
  assign port_reg[0] = rd_reg_a;
  assign port_reg[1] = rd_reg_b;

  for (genvar gi = 0; gi < NUM_TRD; gi++) begin : g_trd
    // Entries 0 and 1 are never written, so they stay at their reset value.
    // The read mux never selects them.
    logic [DATA_W-1:0] regs_q [NUM_REG];
    logic              walk_hit;
    logic              wr_hit;

    assign walk_hit = walk_we && (wtrd_q == TRD_W'(gi));
    assign wr_hit   = wr_fire && (wr_trd == TRD_W'(gi));

    // Thread slice update. The walker has priority, although the drop rule
    // already rules out a same-thread collision.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int r = 0; r < NUM_REG; r++) begin
          regs_q[r] <= '0;
        end
      end else if (walk_hit) begin
        regs_q[widx_q] <= walk_data;
      end else if (wr_hit) begin
        regs_q[wr_reg] <= wr_data;
      end
    end

    assign bank_rd[0][gi] = regs_q[rd_reg_a];
    assign bank_rd[1][gi] = regs_q[rd_reg_b];
  end

  // ---------------------------------------------------------------------
  // Read ports with same-cycle bypass
  // ---------------------------------------------------------------------
  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    logic [DATA_W-1:0] val;

    // Read value, highest priority first:
    // - constant for r0/r1;
    // - else the effective write landing on (rd_trd, reg) this cycle;
    // - else the stored value.
    always_comb begin
      val = bank_rd[gp][rd_trd];
      if (port_reg[gp] < REG_W'(2)) begin
        val = port_reg[gp][0] ? DATA_W'(rd_trd) : '0;
      end else if (walk_we && (wtrd_q == rd_trd) && (widx_q == port_reg[gp])) begin
        val = walk_data;
      end else if (wr_fire && (wr_trd == rd_trd) && (wr_reg == port_reg[gp])) begin
        val = wr_data;
      end
    end

    assign port_val[gp] = val;
  end

  // Output registers give the one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= port_val[0];
      data_b_q <= port_val[1];
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: tb/tb_mt_regfile.sv
// Directed testbench for mt_regfile. Each scenario is a task that drives
// stimulus and checks the outputs 1 ns after the rising edge.
module tb_mt_regfile;

  localparam int TRD_W  = 3;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [TRD_W-1:0]  rd_trd;
  logic [REG_W-1:0]  rd_reg_a;
  logic [REG_W-1:0]  rd_reg_b;
  logic              wr_en;
  logic [TRD_W-1:0]  wr_trd;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              init_req;
  logic [TRD_W-1:0]  init_trd;
  logic [DATA_W-1:0] init_data;
  logic              init_ready;
  logic              init_done;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;

  int errors = 0;
  int checks = 0;

  mt_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_trd     (rd_trd),
    .rd_reg_a   (rd_reg_a),
    .rd_reg_b   (rd_reg_b),
    .wr_en      (wr_en),
    .wr_trd     (wr_trd),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .init_req   (init_req),
    .init_trd   (init_trd),
    .init_data  (init_data),
    .init_ready (init_ready),
    .init_done  (init_done),
    .data_a     (data_a),
    .data_b     (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then step 1 ns off the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_trd = '0; wr_reg = '0; wr_data = '0;
    init_req = 1'b0; init_trd = '0; init_data = '0;
    rd_trd = 3'd5; rd_reg_a = 5'd1; rd_reg_b = 5'd1;
    repeat (3) cyc();
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL reset_hold_a got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL reset_hold_b got=%h exp=%h", data_b, 32'h0); end
    checks++; if (init_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", init_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", init_done); end
    rst_n = 1'b1;
    rd_trd = 3'd5; rd_reg_a = 5'd1; rd_reg_b = 5'd2;
    cyc();
    checks++; if (data_a !== 32'd5) begin errors++; $display("FAIL reset_t5_r1 got=%h exp=%h", data_a, 32'd5); end
    checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL reset_t5_r2 got=%h exp=%h", data_b, 32'h0); end
    rd_reg_a = 5'd31;
    cyc();
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL reset_t5_r31 got=%h exp=%h", data_a, 32'h0); end
    $display("reset: t5 r1/r2/r31 read after release");
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_trd = 3'd3; wr_reg = 5'd7; wr_data = 32'hDEAD_BEEF;
    rd_trd = 3'd0; rd_reg_a = 5'd0; rd_reg_b = 5'd0;
    cyc();
    wr_en = 1'b0; rd_trd = 3'd3; rd_reg_a = 5'd7; rd_reg_b = 5'd7;
    cyc();
    checks++; if (data_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_t3_r7 got=%h exp=%h", data_a, 32'hDEAD_BEEF); end
    rd_trd = 3'd4;
    cyc();
    checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL wr_t4_r7 got=%h exp=%h", data_b, 32'h0); end
    wr_en = 1'b1; wr_trd = 3'd3; wr_reg = 5'd0; wr_data = 32'hFFFF_FFFF;
    cyc();
    wr_reg = 5'd1;
    cyc();
    wr_en = 1'b0; rd_trd = 3'd3; rd_reg_a = 5'd0; rd_reg_b = 5'd1;
    cyc();
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL wr_r0_drop got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'd3) begin errors++; $display("FAIL wr_r1_drop got=%h exp=%h", data_b, 32'd3); end
    $display("write_read: t3 r7, t4 r7, r0/r1 drop");
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_trd = 3'd2; wr_reg = 5'd9; wr_data = 32'h1234;
    rd_trd = 3'd2; rd_reg_a = 5'd9; rd_reg_b = 5'd9;
    cyc();
    checks++; if (data_a !== 32'h1234) begin errors++; $display("FAIL byp_a got=%h exp=%h", data_a, 32'h1234); end
    checks++; if (data_b !== 32'h1234) begin errors++; $display("FAIL byp_b got=%h exp=%h", data_b, 32'h1234); end
    wr_reg = 5'd1; rd_reg_a = 5'd1; rd_reg_b = 5'd1;
    cyc();
    checks++; if (data_a !== 32'd2) begin errors++; $display("FAIL byp_r1 got=%h exp=%h", data_a, 32'd2); end
    // A write to another thread must not be forwarded.
    wr_trd = 3'd5; wr_reg = 5'd9; wr_data = 32'h55;
    rd_trd = 3'd2; rd_reg_a = 5'd9; rd_reg_b = 5'd10;
    cyc();
    checks++; if (data_a !== 32'h1234) begin errors++; $display("FAIL byp_other_trd got=%h exp=%h", data_a, 32'h1234); end
    wr_en = 1'b0;
    $display("bypass: same-cycle forward, r1 forward, no cross-thread forward");
  endtask

  task automatic test_init();
    int low_cnt;
    int done_k;
    int wait_n;
    logic [2:0]  t_trd [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd6, 3'd1, 3'd1};
    logic [4:0]  t_ra  [7] = '{5'd2, 5'd4, 5'd9, 5'd25, 5'd20, 5'd2, 5'd3};
    logic [4:0]  t_rb  [7] = '{5'd3, 5'd5, 5'd20, 5'd31, 5'd1, 5'd4, 5'd31};
    logic [31:0] t_ea  [7] = '{32'hDFFC, 32'hA5A5, 32'h0, 32'h0, 32'h7, 32'hEFFC, 32'hEFFC};
    logic [31:0] t_eb  [7] = '{32'hDFFC, 32'h0, 32'h0, 32'h0, 32'h6, 32'h77, 32'h0};
    // Accept cycle: a write to the walked thread is dropped and not forwarded.
    wr_en = 1'b1; wr_trd = 3'd2; wr_reg = 5'd25; wr_data = 32'h9;
    rd_trd = 3'd2; rd_reg_a = 5'd25; rd_reg_b = 5'd25;
    init_req = 1'b1; init_trd = 3'd2; init_data = 32'hA5A5;
    cyc();
    wr_en = 1'b0; init_req = 1'b0;
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL init_accept_drop got=%h exp=%h", data_a, 32'h0); end
    low_cnt = init_ready ? 0 : 1;
    done_k = -1;
    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      case (k)
        1: begin rd_trd = 3'd2; rd_reg_a = 5'd2; rd_reg_b = 5'd3; end
        2: begin rd_reg_a = 5'd25; rd_reg_b = 5'd25; end
        3: begin wr_en = 1'b1; wr_trd = 3'd2; wr_reg = 5'd20; wr_data = 32'h7; end
        4: begin wr_trd = 3'd6; rd_trd = 3'd2; rd_reg_a = 5'd20; rd_reg_b = 5'd20; end
        5: begin wr_en = 1'b0; rd_trd = 3'd6; rd_reg_a = 5'd20; rd_reg_b = 5'd20; end
        8: begin init_req = 1'b1; init_trd = 3'd1; init_data = 32'h77; end
        default: ;
      endcase
      cyc();
      if (!init_ready) low_cnt++;
      if (init_done) done_k = k;
      case (k)
        1: begin
          checks++; if (data_a !== 32'hDFFC) begin errors++; $display("FAIL walk_byp_r2 got=%h exp=%h", data_a, 32'hDFFC); end
          checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL walk_r3_unwritten got=%h exp=%h", data_b, 32'h0); end
        end
        2: begin
          checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL walk_accept_r25 got=%h exp=%h", data_a, 32'h0); end
        end
        4: begin
          checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL walk_t2_r20_drop got=%h exp=%h", data_a, 32'h0); end
        end
        5: begin
          checks++; if (data_a !== 32'h7) begin errors++; $display("FAIL walk_t6_r20_wr got=%h exp=%h", data_a, 32'h7); end
        end
        default: ;
      endcase
    end
    checks++; if (done_k !== 30) begin errors++; $display("FAIL init_done_time got=%0d exp=%0d", done_k, 30); end
    checks++; if (low_cnt !== 30) begin errors++; $display("FAIL init_ready_low got=%0d exp=%0d", low_cnt, 30); end
    $display("init t2: done after %0d cycles, ready low %0d cycles", done_k, low_cnt);
    // The held thread-1 request is accepted in the init_done cycle.
    cyc();
    init_req = 1'b0;
    checks++; if (init_ready !== 1'b0) begin errors++; $display("FAIL init_b2b_accept got=%b exp=0", init_ready); end
    wait_n = 0;
    while (!init_done && wait_n < 40) begin
      cyc();
      wait_n++;
    end
    checks++; if (wait_n !== 30) begin errors++; $display("FAIL init_t1_done_time got=%0d exp=%0d", wait_n, 30); end
    $display("init t1: done after %0d cycles", wait_n);
    for (int i = 0; i < 7; i++) begin
      rd_trd = t_trd[i]; rd_reg_a = t_ra[i]; rd_reg_b = t_rb[i];
      cyc();
      checks++; if (data_a !== t_ea[i]) begin errors++; $display("FAIL ctx_a[%0d] t%0d r%0d got=%h exp=%h", i, t_trd[i], t_ra[i], data_a, t_ea[i]); end
      checks++; if (data_b !== t_eb[i]) begin errors++; $display("FAIL ctx_b[%0d] t%0d r%0d got=%h exp=%h", i, t_trd[i], t_rb[i], data_b, t_eb[i]); end
      $display("ctx read t%0d r%0d=%h r%0d=%h", t_trd[i], t_ra[i], data_a, t_rb[i], data_b);
    end
  endtask

  task automatic test_mid_walk_reset();
    int pulses;
    init_req = 1'b1; init_trd = 3'd5; init_data = 32'hBEEF;
    cyc();
    init_req = 1'b0;
    repeat (9) cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (init_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", init_ready); end
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL midrst_data_a got=%h exp=%h", data_a, 32'h0); end
    pulses = 0;
    repeat (2) begin
      cyc();
      if (init_done) pulses++;
    end
    rst_n = 1'b1;
    repeat (35) begin
      cyc();
      if (init_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
    rd_trd = 3'd5; rd_reg_a = 5'd2; rd_reg_b = 5'd4;
    cyc();
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL midrst_t5_r2 got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL midrst_t5_r4 got=%h exp=%h", data_b, 32'h0); end
    rd_trd = 3'd6; rd_reg_a = 5'd20; rd_reg_b = 5'd1;
    cyc();
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL midrst_t6_r20 got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'd6) begin errors++; $display("FAIL midrst_t6_r1 got=%h exp=%h", data_b, 32'd6); end
    $display("mid-walk reset: %0d done pulses, context cleared", pulses);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_init();
    test_mid_walk_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation timeout");
  end

endmodule
